// File: rtl/uart_snd.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_snd
//  Purpose  : 8N1 UART transmitter with a small byte FIFO in front of it.
//  Revision : 1.0
// ============================================================================
module uart_snd #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       we,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       txd
);

    localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);

    localparam logic [c_cnt_w-1:0] c_baud_last = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_ptr_w:0]   c_depth     = (c_ptr_w + 1)'(FIFO_DEPTH);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_start = 2'd1;
    localparam logic [1:0] c_st_data  = 2'd2;
    localparam logic [1:0] c_st_stop  = 2'd3;

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_baud;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;
    logic               r_txd;
    logic               r_busy;

    logic [1:0]         w_state_nxt;
    logic [c_cnt_w-1:0] w_baud_nxt;
    logic [2:0]         w_bit_nxt;
    logic [7:0]         w_shift_nxt;
    logic               w_txd_nxt;
    logic               w_pop;
    logic               w_wr;
    logic               w_bit_end;
    logic               w_empty;
    logic               w_full;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_depth);
    // Full is judged on the registered count, so a same-edge pop never frees room.
    assign w_wr      = we && !w_full;
    assign w_bit_end = (r_baud == c_baud_last);

    assign full  = w_full;
    assign empty = w_empty;
    assign busy  = r_busy;
    assign txd   = r_txd;

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;

        if (r_state != c_st_idle) begin
            w_baud_nxt = w_bit_end ? '0 : r_baud + c_cnt_w'(1);
        end

        case (r_state)
            c_st_idle: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rd_ptr];
                    w_baud_nxt  = '0;
                    w_state_nxt = c_st_start;
                end
            end
            c_st_start: begin
                if (w_bit_end) begin
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = c_st_data;
                end
            end
            c_st_data: begin
                if (w_bit_end) begin
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_nxt = c_st_stop;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end
            end
            c_st_stop: begin
                if (w_bit_end) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = r_mem[r_rd_ptr];
                        w_state_nxt = c_st_start;
                    end else begin
                        w_state_nxt = c_st_idle;
                    end
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase

        // Line level follows the state being entered so txd changes on the same edge.
        case (w_state_nxt)
            c_st_start: w_txd_nxt = 1'b0;
            c_st_data:  w_txd_nxt = w_shift_nxt[0];
            default:    w_txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_txd   <= w_txd_nxt;
            r_busy  <= (w_state_nxt != c_st_idle);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_snd.md
# uart_snd

UART transmitter: serialises bytes onto `txd` as 8N1 frames (one start bit, eight data bits LSB first, one stop bit). Bytes are written into a small internal FIFO so software-side logic can queue several bytes without waiting per frame. It is the transmit counterpart of `uart_rcv` and shares its bit timing, so a `uart_snd` → `uart_rcv` loopback must reproduce every byte exactly.

## Interface
Parameters:
- `CLKS_PER_BIT`, 4, clock cycles per bit period. The default matches the simulation setup of 4 MHz `clk` and 1 Mbaud. Legal range is ≥ 2.
- `FIFO_DEPTH`, 4, number of byte entries in the FIFO. Must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `din`  in  8  byte to enqueue.
- `we`  in  1  write strobe. `din` is accepted on any rising edge where `we && !full`.
- `full`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `empty`  out  1  FIFO holds 0 entries.
- `busy`  out  1  a frame is in progress (state ≠ IDLE).
- `txd`  out  1  serial line. Idle level is 1.

## Operation
- **Reset (asynchronous, immediate):**
  - `txd`=1, `busy`=0, `full`=0, `empty`=1.
  - FIFO read/write pointers and count = 0.
  - State = IDLE; baud counter and bit counter = 0.
- **FIFO:** circular buffer with a count of width log2(`FIFO_DEPTH`)+1.
  - Write when `we && !full`. Writes while `full` are dropped silently; this holds even if a pop occurs on the same edge.
  - Pop happens only on the IDLE→START or STOP→START transition.
  - A simultaneous accepted write and pop leaves the count unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **State machine.** The baud counter counts 0..`CLKS_PER_BIT`-1; "bit end" means the counter equals `CLKS_PER_BIT`-1.
  - IDLE: `txd`=1. If `!empty`, pop the FIFO head into the 8-bit shift register, clear the baud counter, and go to START.
  - START: `txd`=0. At bit end, go to DATA with bit counter = 0.
  - DATA: `txd`=shift[0]. At bit end, shift right. If the bit counter = 7, go to STOP; otherwise increment the bit counter.
  - STOP: `txd`=1. At bit end, if `!empty`, pop and go directly to START (no idle gap); otherwise go to IDLE.
- `txd` is driven from a register. It must never glitch and never output X after reset.
- `busy` is registered and is 1 in START, DATA and STOP.
- `full` and `empty` are derived from the count; they are registered or a direct decode of registered state.

## Timing
- A write accepted at edge N into an empty FIFO while IDLE:
  - `empty` goes low after edge N.
  - At edge N+1 the byte is popped, `txd` goes 0 and `busy` goes 1.
  - `empty` returns high after edge N+1, unless another write was accepted.
- Each bit holds for exactly `CLKS_PER_BIT` cycles. A frame is exactly 10×`CLKS_PER_BIT` cycles.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- After the last queued frame, `busy` and state return to IDLE at the edge ending the stop bit.
- Writes are accepted in every state, including mid-frame; the shift register is unaffected by them.
- A reset asserted mid-frame forces `txd`=1 at once, abandons the frame and clears the FIFO. After release, nothing is transmitted until the next write.

## Test plan
- **Single byte 0x5A** (`CLKS_PER_BIT`=4):
  - Required `txd`, 4 cycles per symbol: 0, 0,1,0,1,1,0,1,0, 1.
  - `busy` is high for exactly 40 cycles, then `txd` stays 1.
- **Loopback into `uart_rcv`:** write 0x2D then 0x0F back-to-back.
  - `txd` shows no idle gap between the two frames.
  - The receiver reports 0x2D then 0x0F with `err`=0.
- **FIFO fill:** write 6 bytes on consecutive cycles while idle.
  - The first byte pops at the second edge, so 4 are accepted and `full`=1.
  - The 6th byte is dropped.
  - Exactly 5 frames are transmitted, in order, over 200 cycles.
- **Write when full with simultaneous pop:** hold `full`=1 until a STOP→START pop.
  - A `we` on that same edge is dropped.
  - The count is DEPTH-1 afterwards.
- **Reset mid-frame:** assert `rst_n`=0 during DATA bit 3.
  - `txd`=1, `busy`=0, `empty`=1 immediately.
  - After release `txd` stays 1 for 50 cycles with no writes.
- **Wrap-around:** stream 20 incrementing bytes 0x00..0x13, writing whenever `!full`.
  - All 20 are received in order by `uart_rcv`.
  - The pointers wrap 5 times.
